debayer_line_sequencer: RTL and testbench

DEBAYER_LINE_SEQUENCER -- requirements
Module: debayer_line_sequencer

---
 rtl/debayer_line_sequencer.sv | 122 ++++++++++++
 tb/tb_debayer_line_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/debayer_line_sequencer.sv
`default_nettype none
// debayer_line_sequencer: delays a 2-pixel raw Bayer stream by one cycle and pairs each word with the same-column word of the previous line.
// Build option DEBAYER_FIRST_LINE_REPLICATE_EN: on a frame's first line the previous-line word mirrors the current word instead of reading 0.
module debayer_line_sequencer #(
  parameter int MAX_PAIRS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_den,
  input  logic [19:0]       in_data,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_den,
  output logic              out_line_start,
  output logic              out_odd_line,
  output logic [19:0]       out_data,
  output logic [19:0]       out_prev_line_data,
  output logic [11:0]       line_count,
  output logic [ADDR_W:0]   line_pairs,
  output logic              overflow
);

`ifdef DEBAYER_FIRST_LINE_REPLICATE_EN
  localparam logic C_REPLICATE = 1'b1;
`else
  localparam logic C_REPLICATE = 1'b0;
`endif
  localparam logic [ADDR_W:0] C_MAX     = MAX_PAIRS[ADDR_W:0];
  localparam logic [ADDR_W:0] C_CNT_SAT = '1;

  logic [19:0]     r_mem [MAX_PAIRS];
  logic [19:0]     r_rd_data;
  logic [ADDR_W:0] r_cnt;
  logic            r_first;
  logic            r_prev_zero;
  logic            r_prev_rep;

  // out_den / out_vsync double as the previous-cycle copies of the inputs for edge detection.
  logic            w_line_start;
  logic            w_line_end;
  logic            w_frame_start;
  logic [ADDR_W:0] w_cnt;
  logic            w_in_range;
  logic            w_access;
  logic [ADDR_W-1:0] w_addr;

  assign w_line_start  = in_den & ~out_den;
  assign w_line_end    = out_den & ~in_den;
  assign w_frame_start = in_vsync & ~out_vsync;
  assign w_cnt         = w_line_start ? '0 : r_cnt;
  assign w_in_range    = (w_cnt < C_MAX);
  assign w_access      = reset_n & in_den & w_in_range;
  assign w_addr        = w_cnt[ADDR_W-1:0];

  // Read-first single-port line buffer; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_access) begin
      r_rd_data     <= r_mem[w_addr];
      r_mem[w_addr] <= in_data;
    end
  end

  assign out_prev_line_data = r_prev_zero ? 20'd0 :
                              r_prev_rep  ? out_data : r_rd_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_hsync      <= 1'b0;
      out_vsync      <= 1'b0;
      out_den        <= 1'b0;
      out_line_start <= 1'b0;
      out_odd_line   <= 1'b0;
      out_data       <= 20'd0;
      line_count     <= 12'd0;
      line_pairs     <= '0;
      overflow       <= 1'b0;
      r_cnt          <= '0;
      r_first        <= 1'b1;
      r_prev_zero    <= 1'b1;
      r_prev_rep     <= 1'b0;
    end else begin
      out_hsync      <= in_hsync;
      out_vsync      <= in_vsync;
      out_den        <= in_den;
      out_line_start <= w_line_start;
      out_data       <= in_data;

      if (in_den) begin
        r_cnt       <= (w_cnt == C_CNT_SAT) ? w_cnt : w_cnt + 1'b1;
        r_prev_zero <= ~w_in_range | (r_first & ~C_REPLICATE);
        r_prev_rep  <= w_in_range & r_first & C_REPLICATE;
      end

      if (w_line_end) begin
        line_pairs <= r_cnt;
      end

      if (w_frame_start) begin
        out_odd_line <= 1'b0;
        line_count   <= 12'd0;
        overflow     <= 1'b0;
        r_first      <= 1'b1;
      end else if (w_line_end) begin
        out_odd_line <= ~out_odd_line;
        if (line_count != 12'hFFF) begin
          line_count <= line_count + 12'd1;
        end
        r_first <= 1'b0;
      end

      // An out-of-range word belongs to the new frame even if vsync rose this cycle.
      if (in_den && !w_in_range) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debayer_line_sequencer.sv
`default_nettype none
// tb_debayer_line_sequencer: directed and randomized frames checked every cycle against a column-indexed behavioural model.
module tb_debayer_line_sequencer;

  localparam int MAXP = 1024;
`ifdef DEBAYER_FIRST_LINE_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_hsync = 1'b0, in_vsync = 1'b0, in_den = 1'b0;
  logic [19:0] in_data = 20'd0;
  logic        out_hsync, out_vsync, out_den, out_line_start, out_odd_line, overflow;
  logic [19:0] out_data, out_prev_line_data;
  logic [11:0] line_count;
  logic [10:0] line_pairs;

  int checks = 0;
  int failures = 0;

  debayer_line_sequencer #(.MAX_PAIRS(MAXP), .ADDR_W(10)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_den(in_den), .in_data(in_data),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_den(out_den),
    .out_line_start(out_line_start), .out_odd_line(out_odd_line),
    .out_data(out_data), .out_prev_line_data(out_prev_line_data),
    .line_count(line_count), .line_pairs(line_pairs), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Behavioural model: previous line held as a column-indexed array.
  logic [19:0] mem [MAXP];
  bit          mval [MAXP];
  bit m_first = 1, m_odd = 0, m_ovf = 0, m_pden = 0, m_pvs = 0;
  int m_lc = 0, m_lp = 0, m_col = 0;
  bit e_hs, e_vs, e_den, e_ls, e_odd, e_ovf, e_pvalid;
  logic [19:0] e_data, e_prev;
  int e_lc, e_lp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit rn, input bit hs, input bit vs, input bit de, input logic [19:0] d);
    bit fs, le;
    int col;
    if (!rn) begin
      m_first = 1; m_odd = 0; m_ovf = 0; m_pden = 0; m_pvs = 0;
      m_lc = 0; m_lp = 0; m_col = 0;
      e_hs = 0; e_vs = 0; e_den = 0; e_ls = 0; e_data = 0; e_prev = 0; e_pvalid = 1;
    end else begin
      fs = vs && !m_pvs;
      le = m_pden && !de;
      e_hs = hs; e_vs = vs; e_den = de; e_data = d;
      e_ls = de && !m_pden;
      e_pvalid = 1;
      if (de) begin
        col = m_pden ? m_col : 0;
        if (col >= MAXP) e_prev = 20'd0;
        else begin
          if (m_first) e_prev = REP ? d : 20'd0;
          else begin e_prev = mem[col]; e_pvalid = mval[col]; end
          mem[col] = d; mval[col] = 1;
        end
        m_col = (col >= 2047) ? 2047 : col + 1;
      end
      if (le) m_lp = m_col;
      if (fs) begin m_odd = 0; m_lc = 0; m_ovf = 0; m_first = 1; end
      else if (le) begin m_odd = !m_odd; if (m_lc < 4095) m_lc++; m_first = 0; end
      if (de && col >= MAXP) m_ovf = 1;
      m_pden = de; m_pvs = vs;
    end
    e_odd = m_odd; e_lc = m_lc; e_lp = m_lp; e_ovf = m_ovf;
  endtask

  // Drive one cycle, then compare every DUT output against the model.
  task automatic step(input bit rn, input bit hs, input bit vs, input bit de, input logic [19:0] d);
    reset_n = rn; in_hsync = hs; in_vsync = vs; in_den = de; in_data = d;
    @(posedge clock);
    #1;
    model(rn, hs, vs, de, d);
    chk("hsync", out_hsync, e_hs);
    chk("vsync", out_vsync, e_vs);
    chk("den", out_den, e_den);
    chk("line_start", out_line_start, e_ls);
    chk("odd_line", out_odd_line, e_odd);
    chk("line_count", line_count, e_lc);
    chk("line_pairs", line_pairs, e_lp);
    chk("overflow", overflow, e_ovf);
    if (e_den || !rn) chk("data", out_data, e_data);
    if ((e_den && e_pvalid) || !rn) chk("prev_line_data", out_prev_line_data, e_prev);
  endtask

  task automatic vsync_pulse();
    step(1, 0, 1, 0, 20'd0);
    step(1, 0, 0, 0, 20'd0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 20'd0);
  endtask

  initial begin
    for (int i = 0; i < MAXP; i++) mval[i] = 0;

    // Reset state
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 20'd0);
    chk("rst_line_count", line_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_odd", out_odd_line, 0);

    // 4 lines x 8 words, data = line*16+col
    vsync_pulse();
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 8; c++) begin
        step(1, 0, 0, 1, 20'(l * 16 + c));
        if (c == 0) chk("odd_seq", out_odd_line, l % 2);
        if (l == 2 && c == 3) chk("l2c3_prev", out_prev_line_data, 20'h00013);
      end
      gap(1);
      if (l == 3) begin
        chk("frame_line_count", line_count, 4);
        chk("frame_line_pairs", line_pairs, 8);
      end
      gap(2);
    end

    // First-line handling
    vsync_pulse();
    step(1, 0, 0, 1, 20'h12345);
    chk("first_line_prev", out_prev_line_data, REP ? 20'h12345 : 20'h00000);
    for (int c = 1; c < 4; c++) step(1, 0, 0, 1, 20'($urandom));
    gap(3);

    // Overflow: one line of 1030 words
    vsync_pulse();
    for (int i = 0; i < 1030; i++) begin
      step(1, 0, 0, 1, 20'($urandom));
      if (i == 1023) chk("ovf_before", overflow, 0);
      if (i >= 1024) begin
        chk("ovf_set", overflow, 1);
        chk("ovf_prev_zero", out_prev_line_data, 0);
      end
    end
    gap(1);
    chk("ovf_line_pairs", line_pairs, 1030);
    gap(2);
    step(1, 0, 1, 0, 20'd0);
    chk("ovf_cleared", overflow, 0);
    step(1, 0, 0, 0, 20'd0);

    // Line end coinciding with frame start
    vsync_pulse();
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 5; c++) step(1, 0, 0, 1, 20'($urandom));
      if (l < 3) gap(2);
    end
    step(1, 0, 1, 0, 20'd0);
    chk("coinc_line_pairs", line_pairs, 5);
    chk("coinc_line_count", line_count, 0);
    chk("coinc_odd", out_odd_line, 0);
    step(1, 0, 0, 0, 20'd0);
    step(1, 0, 0, 1, 20'h0ABCD);
    chk("coinc_next_ls", out_line_start, 1);
    chk("coinc_next_odd", out_odd_line, 0);
    gap(2);

    // Reset pulse mid-line
    vsync_pulse();
    for (int c = 0; c < 6; c++) step(1, 0, 0, 1, 20'($urandom));
    gap(2);
    for (int c = 0; c < 5; c++) step(1, 0, 0, 1, 20'($urandom));
    step(0, 0, 0, 1, 20'h55555);
    chk("rst_mid_den", out_den, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_prev", out_prev_line_data, 0);
    chk("rst_mid_pairs", line_pairs, 0);
    step(1, 0, 0, 0, 20'd0);
    step(1, 0, 0, 1, 20'h2468A);
    chk("rst_next_ls", out_line_start, 1);
    chk("rst_next_odd", out_odd_line, 0);
    chk("rst_next_prev", out_prev_line_data, REP ? 20'h2468A : 20'h00000);
    gap(2);

    // Random frames with random line lengths and 1-3 cycle den gaps
    for (int f = 0; f < 8; f++) begin
      vsync_pulse();
      for (int l = 0; l < int'($urandom_range(2, 7)); l++) begin
        for (int c = 0; c < int'($urandom_range(1, 24)); c++)
          step(1, $urandom_range(0, 3) == 0, 0, 1, 20'($urandom));
        gap(int'($urandom_range(1, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
